multi_port_free_list: RTL and testbench

- Registered occupancy table with multi-lane allocate and multi-lane free, for physical-register and tag allocation in the rename stage.
- Successor to the single-result priority_encoder: grants up to ALLOC_WIDTH lowest-numbered free entries per cycle.
- Accepts up to FREE_WIDTH releases per cycle from commit, and supports flush to the reset image.
- Owns the busy table itself. Bit value 1 = in use, 0 = free, matching the codebase convention.

---
 rtl/free_list_pkg.sv | 25 ++
 rtl/multi_port_free_list_if.sv | 34 +++
 rtl/priority_encoder.sv | 24 ++
 rtl/multi_port_free_list.sv | 92 +++++++++
 tb/tb_multi_port_free_list.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/free_list_pkg.sv
// Shared types and constants for the multi-lane free list.
// Widths in the package describe the default 64-entry build; instances derive their own widths from these helpers.
package free_list_pkg;

  localparam int MAX_ENTRIES     = 1024;
  localparam int DEF_ENTRY_COUNT = 64;
  localparam int DEF_CNT_W       = $clog2(DEF_ENTRY_COUNT) + 1;

  typedef logic [$clog2(DEF_ENTRY_COUNT)-1:0] idx_t;

  function automatic int count_width(input int entries);
    return $clog2(entries) + 1;
  endfunction

  // Low 'reserved' bits set: entries held by architectural mappings at reset and flush.
  function automatic logic [MAX_ENTRIES-1:0] reset_image(input int reserved);
    logic [MAX_ENTRIES-1:0] img;
    img = '0;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (i < reserved) img[i] = 1'b1;
    end
    return img;
  endfunction

endpackage

// File: rtl/multi_port_free_list_if.sv
// Allocate/free/flush bundle between the rename stage (master) and the free list (slave).
// Grants are combinational; frees and flush take effect on the next clock edge.
interface multi_port_free_list_if
  import free_list_pkg::*;
#(
  parameter int ENTRY_COUNT = 64,
  parameter int ALLOC_WIDTH = 2,
  parameter int FREE_WIDTH  = 2
);
  localparam int IDX_W = $clog2(ENTRY_COUNT);
  localparam int CNT_W = count_width(ENTRY_COUNT);

  logic [ALLOC_WIDTH-1:0]       alloc_req;
  logic [ALLOC_WIDTH*IDX_W-1:0] alloc_index;
  logic [ALLOC_WIDTH-1:0]       alloc_valid;
  logic [FREE_WIDTH-1:0]        free_valid;
  logic [FREE_WIDTH*IDX_W-1:0]  free_index;
  logic                         flush;
  logic [ENTRY_COUNT-1:0]       busy_table;
  logic [CNT_W-1:0]             free_count;
  logic                         full;
  logic                         err_double_free;

  modport master (
    output alloc_req, free_valid, free_index, flush,
    input  alloc_index, alloc_valid, busy_table, free_count, full, err_double_free
  );

  modport slave (
    input  alloc_req, free_valid, free_index, flush,
    output alloc_index, alloc_valid, busy_table, free_count, full, err_double_free
  );

endinterface

// File: rtl/priority_encoder.sv
// Finds the lowest-numbered zero (free) bit of free_table; combinational, zero latency.
// valid=0 and free_index=0 when every bit is set.
module priority_encoder #(
  parameter int ENTRY_COUNT = 64
) (
  input  logic [ENTRY_COUNT-1:0]         free_table,
  output logic [$clog2(ENTRY_COUNT)-1:0] free_index,
  output logic                           valid
);
  localparam int IDX_W = $clog2(ENTRY_COUNT);

  // Scan downward so the last hit is the lowest free index.
  always_comb begin
    free_index = '0;
    valid      = 1'b0;
    for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
      if (!free_table[i]) begin
        free_index = IDX_W'(i);
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_port_free_list.sv
// Busy table with ALLOC_WIDTH zero-latency grants of the lowest free entries and FREE_WIDTH releases per cycle.
// Table, count and sticky double-free flag update on the edge; no grant when too few entries are free.
module multi_port_free_list
  import free_list_pkg::*;
#(
  parameter int ENTRY_COUNT = 64,
  parameter int ALLOC_WIDTH = 2,
  parameter int FREE_WIDTH  = 2,
  parameter int RESERVED    = 0
) (
  input logic                    clk,
  input logic                    rst,
  multi_port_free_list_if.slave  fl
);
  localparam int IDX_W = $clog2(ENTRY_COUNT);
  localparam int CNT_W = count_width(ENTRY_COUNT);
  localparam logic [MAX_ENTRIES-1:0] RST_WIDE = reset_image(RESERVED);
  localparam logic [ENTRY_COUNT-1:0] RST_IMG  = RST_WIDE[ENTRY_COUNT-1:0];
  localparam logic [CNT_W-1:0]       RST_CNT  = CNT_W'(ENTRY_COUNT - RESERVED);

  logic [ENTRY_COUNT-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]       free_count_q, free_count_d;
  logic                   err_q, err_d;

  logic [ENTRY_COUNT-1:0] stage_mask [ALLOC_WIDTH+1];
  logic [IDX_W-1:0]       pe_index   [ALLOC_WIDTH];
  logic [ALLOC_WIDTH-1:0] pe_valid;
  logic [ALLOC_WIDTH-1:0] grant;
  logic [ENTRY_COUNT-1:0] granted_mask;
  logic [ENTRY_COUNT-1:0] freed_mask;
  logic                   dbl_free;

  // Each stage sees the table plus the grants already handed to lower lanes.
  assign stage_mask[0] = busy_q;

  for (genvar k = 0; k < ALLOC_WIDTH; k++) begin : g_lane
    priority_encoder #(.ENTRY_COUNT(ENTRY_COUNT)) u_pe (
      .free_table (stage_mask[k]),
      .free_index (pe_index[k]),
      .valid      (pe_valid[k])
    );
    assign grant[k]         = fl.alloc_req[k] & pe_valid[k];
    assign stage_mask[k+1]  = grant[k] ? (stage_mask[k] | (ENTRY_COUNT'(1) << pe_index[k]))
                                       : stage_mask[k];
    assign fl.alloc_index[k*IDX_W +: IDX_W] = grant[k] ? pe_index[k] : '0;
  end

  assign granted_mask = stage_mask[ALLOC_WIDTH] & ~busy_q;

  always_comb begin
    freed_mask   = '0;
    dbl_free     = 1'b0;
    for (int f = 0; f < FREE_WIDTH; f++) begin
      if (fl.free_valid[f]) begin
        freed_mask[fl.free_index[f*IDX_W +: IDX_W]] = 1'b1;
        if (!busy_q[fl.free_index[f*IDX_W +: IDX_W]]) dbl_free = 1'b1;
      end
    end

    // A same-cycle grant overrides a free of that entry.
    busy_d = (busy_q | granted_mask) & ~(freed_mask & ~granted_mask);
    err_d  = err_q | dbl_free;
    if (fl.flush) begin
      busy_d = RST_IMG;
      err_d  = err_q;
    end

    free_count_d = '0;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      if (!busy_d[i]) free_count_d = free_count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= RST_IMG;
      free_count_q <= RST_CNT;
      err_q        <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      free_count_q <= free_count_d;
      err_q        <= err_d;
    end
  end

  assign fl.alloc_valid     = grant;
  assign fl.busy_table      = busy_q;
  assign fl.free_count      = free_count_q;
  assign fl.full            = (free_count_q == '0);
  assign fl.err_double_free = err_q;

endmodule

// File: tb/tb_multi_port_free_list.sv
// Directed vector table plus randomized traffic against a list-based reference of the free list (8 entries, 2 reserved).
module tb_multi_port_free_list;
  localparam int N   = 8;
  localparam int AW  = 2;
  localparam int FW  = 2;
  localparam int RES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_port_free_list_if #(.ENTRY_COUNT(N), .ALLOC_WIDTH(AW), .FREE_WIDTH(FW)) fl ();

  multi_port_free_list #(.ENTRY_COUNT(N), .ALLOC_WIDTH(AW), .FREE_WIDTH(FW), .RESERVED(RES)) dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl)
  );

  typedef struct {
    logic [1:0] req;
    logic [1:0] fv;
    int         fi0, fi1;
    logic       fls;
    logic [1:0] ev;
    int         ei0, ei1;
    logic [7:0] eb;
    int         ec;
    logic       ee;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic addv(input logic [1:0] req, input logic [1:0] fv, input int fi0, input int fi1,
                      input logic fls, input logic [1:0] ev, input int ei0, input int ei1,
                      input logic [7:0] eb, input int ec, input logic ee);
    vec_t v;
    v.req = req; v.fv = fv; v.fi0 = fi0; v.fi1 = fi1; v.fls = fls;
    v.ev = ev; v.ei0 = ei0; v.ei1 = ei1; v.eb = eb; v.ec = ec; v.ee = ee;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] fv, input int fi0, input int fi1, input logic fls);
    fl.alloc_req  = req;
    fl.free_valid = fv;
    fl.free_index = {3'(fi1), 3'(fi0)};
    fl.flush      = fls;
  endtask

  // Reference state: one flag per entry plus the sticky error.
  bit m_busy[N];
  bit m_err;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_busy[i] = (i < RES);
    m_err = 1'b0;
  endtask

  function automatic int model_free_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) if (!m_busy[i]) c++;
    return c;
  endfunction

  function automatic logic [7:0] model_table();
    logic [7:0] t;
    for (int i = 0; i < N; i++) t[i] = m_busy[i];
    return t;
  endfunction

  initial begin
    int lane_idx[AW];
    bit lane_ok[AW];
    int free_list[$];
    int r;
    logic [1:0] req, fv;
    int fi[FW];
    logic fls;
    bit was_free[N];
    bit dbl;

    drive(2'b00, 2'b00, 0, 0, 1'b0);

    addv(2'b11, 2'b00, 0, 0, 0, 2'b11, 2, 3, 8'b0000_1111, 4, 0);
    addv(2'b11, 2'b00, 0, 0, 0, 2'b11, 4, 5, 8'b0011_1111, 2, 0);
    addv(2'b11, 2'b00, 0, 0, 0, 2'b11, 6, 7, 8'b1111_1111, 0, 0);
    addv(2'b00, 2'b11, 2, 3, 0, 2'b00, 0, 0, 8'b1111_0011, 2, 0);
    addv(2'b10, 2'b00, 0, 0, 0, 2'b10, 0, 2, 8'b1111_0111, 1, 0);
    addv(2'b01, 2'b01, 7, 0, 0, 2'b01, 3, 0, 8'b0111_1111, 1, 0);
    addv(2'b11, 2'b00, 0, 0, 0, 2'b01, 7, 0, 8'b1111_1111, 0, 0);
    addv(2'b11, 2'b00, 0, 0, 0, 2'b00, 0, 0, 8'b1111_1111, 0, 0);
    addv(2'b11, 2'b01, 5, 0, 0, 2'b00, 0, 0, 8'b1101_1111, 1, 0);
    addv(2'b11, 2'b00, 0, 0, 0, 2'b01, 5, 0, 8'b1111_1111, 0, 0);
    addv(2'b00, 2'b11, 6, 6, 0, 2'b00, 0, 0, 8'b1011_1111, 1, 0);
    addv(2'b00, 2'b01, 6, 0, 0, 2'b00, 0, 0, 8'b1011_1111, 1, 1);
    addv(2'b11, 2'b01, 0, 0, 1, 2'b01, 6, 0, 8'b0000_0011, 6, 1);
    addv(2'b00, 2'b10, 0, 0, 0, 2'b00, 0, 0, 8'b0000_0010, 7, 1);
    addv(2'b11, 2'b00, 0, 0, 0, 2'b11, 0, 2, 8'b0000_0111, 5, 1);
    addv(2'b01, 2'b01, 3, 0, 0, 2'b01, 3, 0, 8'b0000_1111, 4, 1);

    repeat (2) @(negedge clk);
    chk("rst_busy", fl.busy_table, 8'b0000_0011);
    chk("rst_count", fl.free_count, 6);
    chk("rst_full", fl.full, 0);
    chk("rst_err", fl.err_double_free, 0);
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].req, vq[i].fv, vq[i].fi0, vq[i].fi1, vq[i].fls);
      #1;
      chk($sformatf("v%0d_valid", i), fl.alloc_valid, vq[i].ev);
      chk($sformatf("v%0d_idx0", i), fl.alloc_index[2:0], vq[i].ei0);
      chk($sformatf("v%0d_idx1", i), fl.alloc_index[5:3], vq[i].ei1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy", i), fl.busy_table, vq[i].eb);
      chk($sformatf("v%0d_count", i), fl.free_count, vq[i].ec);
      chk($sformatf("v%0d_full", i), fl.full, vq[i].ec == 0);
      chk($sformatf("v%0d_err", i), fl.err_double_free, vq[i].ee);
    end

    // Asynchronous reset between edges drops the pending request and clears the sticky flag.
    @(negedge clk);
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", fl.busy_table, 8'b0000_0011);
    chk("arst_count", fl.free_count, 6);
    chk("arst_err", fl.err_double_free, 0);
    chk("arst_valid", fl.alloc_valid, 2'b11);
    chk("arst_idx1", fl.alloc_index[5:3], 3);
    @(negedge clk);
    rst = 1'b0;

    // Granting and freeing the same entry in one cycle: flagged, entry stays busy.
    drive(2'b01, 2'b01, 2, 0, 1'b0);
    #1;
    chk("coll_idx0", fl.alloc_index[2:0], 2);
    @(posedge clk);
    #1;
    chk("coll_busy", fl.busy_table, 8'b0000_0111);
    chk("coll_count", fl.free_count, 5);
    chk("coll_err", fl.err_double_free, 1);

    @(negedge clk);
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();

    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      req = 2'($urandom_range(0, 3));
      fv  = 2'($urandom_range(0, 3));
      for (int f = 0; f < FW; f++) fi[f] = $urandom_range(0, N - 1);
      fls = ($urandom_range(0, 24) == 0);
      drive(req, fv, fi[0], fi[1], fls);

      free_list.delete();
      for (int i = 0; i < N; i++) if (!m_busy[i]) free_list.push_back(i);
      r = 0;
      for (int k = 0; k < AW; k++) begin
        lane_ok[k]  = req[k] && (r < free_list.size());
        lane_idx[k] = lane_ok[k] ? free_list[r] : 0;
        if (lane_ok[k]) r++;
      end

      #1;
      chk($sformatf("r%0d_valid", cyc), fl.alloc_valid, {lane_ok[1], lane_ok[0]});
      chk($sformatf("r%0d_idx0", cyc), fl.alloc_index[2:0], lane_idx[0]);
      chk($sformatf("r%0d_idx1", cyc), fl.alloc_index[5:3], lane_idx[1]);

      if (fls) begin
        for (int i = 0; i < N; i++) m_busy[i] = (i < RES);
      end else begin
        for (int i = 0; i < N; i++) was_free[i] = !m_busy[i];
        dbl = 1'b0;
        for (int f = 0; f < FW; f++) begin
          if (fv[f]) begin
            if (was_free[fi[f]]) dbl = 1'b1;
            m_busy[fi[f]] = 1'b0;
          end
        end
        for (int k = 0; k < AW; k++) if (lane_ok[k]) m_busy[lane_idx[k]] = 1'b1;
        m_err = m_err | dbl;
      end

      @(posedge clk);
      #1;
      chk($sformatf("r%0d_busy", cyc), fl.busy_table, model_table());
      chk($sformatf("r%0d_count", cyc), fl.free_count, model_free_cnt());
      chk($sformatf("r%0d_full", cyc), fl.full, model_free_cnt() == 0);
      chk($sformatf("r%0d_err", cyc), fl.err_double_free, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
